// File: rtl/ssd_pkg.sv
// Shared constants for the four-digit seven-segment scanner.
package ssd_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // Segment byte {a,b,c,d,e,f,g,dp}, active-low; all segments and dp off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {a,b,c,d,e,f,g} pattern for each hex digit (b and d lowercase).
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/seg_hex_enc.sv
// Combinational hex digit to active-low seven-segment pattern.
module seg_hex_enc
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup only; no state.
  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/ssd_scan.sv
// Four-digit multiplexed seven-segment scanner with per-frame shadowing of
// the displayed value, decimal points and leading-zero blanking.
module ssd_scan
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        f_crys,
  input  logic        rst,
  input  logic [15:0] val,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [7:0]  D,
  output logic [3:0]  ssd,
  output logic        frame_tick
);

  localparam int unsigned DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic          first;
  logic [15:0]   sh_val;
  logic [3:0]    sh_dp;
  logic          sh_blank;

  logic          wrap;
  logic          load;
  logic [1:0]    idx_nxt;
  logic [15:0]   sh_val_nxt;
  logic [3:0]    sh_dp_nxt;
  logic          sh_blank_nxt;
  logic [3:0]    digit;
  logic [6:0]    enc_seg;
  logic [6:0]    seg_nxt;
  logic [3:0]    blank_mask;
  logic          zero_above;

  // Next index and shadow contents; outputs are built from these so that
  // the digit shown on a load edge already comes from the fresh shadow.
  always_comb begin
    wrap         = (div == DIV_LAST);
    load         = !rst && (first || (wrap && (idx == 2'd3)));
    idx_nxt      = rst ? 2'd0 : (wrap ? idx + 2'd1 : idx);
    sh_val_nxt   = load ? val      : sh_val;
    sh_dp_nxt    = load ? dp_in    : sh_dp;
    sh_blank_nxt = load ? blank_lz : sh_blank;
    digit        = sh_val_nxt[{idx_nxt, 2'b00} +: 4];
  end

  // Leading-zero mask: walk from the top digit down while digits stay zero.
  always_comb begin
    zero_above = 1'b1;
    blank_mask = '0;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      zero_above = zero_above && (sh_val_nxt[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      blank_mask[NUM_DIGITS-1-k] = sh_blank_nxt && zero_above;
    end
  end

  seg_hex_enc u_enc (
    .hex (digit),
    .seg (enc_seg)
  );

  // Blanked digits drop a-g but keep their decimal point.
  always_comb begin
    seg_nxt = blank_mask[idx_nxt] ? SEG_BLANK[7:1] : enc_seg;
  end

  // Divider, digit index, shadow registers and registered display outputs.
  always_ff @(posedge f_crys) begin
    if (rst) begin
      div        <= '0;
      idx        <= 2'd0;
      first      <= 1'b1;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= 1'b0;
      ssd        <= 4'b1110;
      D          <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      div        <= wrap ? '0 : div + DW'(1);
      idx        <= idx_nxt;
      first      <= 1'b0;
      sh_val     <= sh_val_nxt;
      sh_dp      <= sh_dp_nxt;
      sh_blank   <= sh_blank_nxt;
      ssd        <= ~(4'b0001 << idx_nxt);
      D          <= {seg_nxt, ~sh_dp_nxt[idx_nxt]};
      frame_tick <= load;
    end
  end

endmodule

// File: tb/tb_ssd_scan.sv
// Scoreboard bench for ssd_scan at SCAN_DIV=4 and SCAN_DIV=2.
module tb_ssd_scan;

  typedef struct packed {
    logic [3:0] ssd;
    logic [7:0] d;
    logic       ft;
  } exp_t;

  logic        f_crys = 1'b0;
  logic        rst    = 1'b1;
  logic [15:0] val    = 16'h0000;
  logic [3:0]  dp_in  = 4'h0;
  logic        blank_lz = 1'b0;

  logic [7:0]  d4, d2;
  logic [3:0]  ssd4, ssd2;
  logic        ft4, ft2;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  exp_t q4[$];
  exp_t q2[$];

  always #5 f_crys = ~f_crys;

  ssd_scan #(.SCAN_DIV(4)) dut4 (
    .f_crys(f_crys), .rst(rst), .val(val), .dp_in(dp_in), .blank_lz(blank_lz),
    .D(d4), .ssd(ssd4), .frame_tick(ft4)
  );

  ssd_scan #(.SCAN_DIV(2)) dut2 (
    .f_crys(f_crys), .rst(rst), .val(val), .dp_in(dp_in), .blank_lz(blank_lz),
    .D(d2), .ssd(ssd2), .frame_tick(ft2)
  );

  // Standard hex glyphs, segments a..g, active-low.
  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'b0000001;  4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;  4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;  4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;  4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;  4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;  default: seg7 = 7'b0111000;
    endcase
  endfunction

  // Expected outputs after the n-th edge since reset release (n >= 1):
  // the display position is a pure function of n, shadow is the last load.
  function automatic exp_t model(input int unsigned s, input int unsigned n,
                                 input logic [15:0] v, input logic [3:0] dp,
                                 input logic bl);
    exp_t e;
    int unsigned pos;
    logic [15:0] upper;
    logic        blank;
    pos   = (n / s) % 4;
    upper = v >> (4 * pos);
    blank = bl && (pos != 0) && (upper == 16'h0000);
    e.ssd = ~(4'b0001 << pos);
    e.d   = {blank ? 7'b1111111 : seg7(upper[3:0]), ~dp[pos]};
    e.ft  = (n == 1) || (n % (4 * s) == 0);
    return e;
  endfunction

  // Reference model: one expected entry per DUT per edge.
  int unsigned n_edges = 0;
  logic [15:0] sv4 = '0, sv2 = '0;
  logic [3:0]  sd4 = '0, sd2 = '0;
  logic        sb4 = 1'b0, sb2 = 1'b0;
  always @(posedge f_crys) begin
    if (rst) begin
      n_edges = 0;
      sv4 = '0; sd4 = '0; sb4 = 1'b0;
      sv2 = '0; sd2 = '0; sb2 = 1'b0;
      q4.push_back('{ssd: 4'b1110, d: 8'hFF, ft: 1'b0});
      q2.push_back('{ssd: 4'b1110, d: 8'hFF, ft: 1'b0});
    end else begin
      n_edges = n_edges + 1;
      if (n_edges == 1 || n_edges % 16 == 0) begin
        sv4 = val; sd4 = dp_in; sb4 = blank_lz;
      end
      if (n_edges == 1 || n_edges % 8 == 0) begin
        sv2 = val; sd2 = dp_in; sb2 = blank_lz;
      end
      q4.push_back(model(4, n_edges, sv4, sd4, sb4));
      q2.push_back(model(2, n_edges, sv2, sd2, sb2));
    end
  end

  task automatic compare(input string name, input exp_t e,
                         input logic [3:0] s, input logic [7:0] d, input logic f);
    vectors++;
    if (s !== e.ssd || d !== e.d || f !== e.ft) begin
      miscompares++;
      $display("FAIL %s t=%0t got ssd=%b D=%b tick=%b required ssd=%b D=%b tick=%b",
               name, $time, s, d, f, e.ssd, e.d, e.ft);
    end
  endtask

  // Monitor: pops one expectation per DUT each cycle, sampled after the edge.
  always @(posedge f_crys) begin
    #1;
    if (q4.size() > 0) compare("div4", q4.pop_front(), ssd4, d4, ft4);
    if (q2.size() > 0) compare("div2", q2.pop_front(), ssd2, d2, ft2);
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge f_crys);
  endtask

  // Bounded wait for a given digit enable on the SCAN_DIV=4 instance.
  task automatic wait_ssd4(input logic [3:0] target, input string name);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge f_crys);
      if (ssd4 === target) found = 1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout got ssd=%b required ssd=%b", name, ssd4, target);
    end
  endtask

  initial begin
    rst = 1'b1; val = 16'h1208; dp_in = 4'h0; blank_lz = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(40);
    blank_lz = 1'b1; val = 16'h0007;
    cyc(32);
    val = 16'h0000;
    cyc(32);
    blank_lz = 1'b0; val = 16'hFA00; dp_in = 4'b0100;
    cyc(32);
    // Mid-frame change of the displayed value.
    dp_in = 4'h0; val = 16'h3C5E;
    cyc(20);
    wait_ssd4(4'b1101, "wait_1101");
    val = 16'h9B4D; dp_in = 4'b1001;
    cyc(32);
    // Mid-frame reset.
    wait_ssd4(4'b1011, "wait_1011");
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(20);
    // Randomised phase biased toward leading zeros.
    for (int i = 0; i < 1500; i++) begin
      @(negedge f_crys);
      if ($urandom_range(0, 6) == 0) val = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    cyc(4);
    if (q4.size() > 1 || q2.size() > 1) begin
      vectors++;
      miscompares++;
      $display("FAIL drain got %0d/%0d pending required <=1", q4.size(), q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ssd_scan.md
SSD_SCAN -- requirements
Module: ssd_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, f_crys cycles each digit is enabled; legal range >= 2.
REQ-002 f_crys  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 val  input  16  four hex digits; digit i = val[4i+3:4i], digit 0 rightmost.
REQ-005 dp_in  input  4  decimal-point request; bit i = digit i, active-high.
REQ-006 blank_lz  input  1  leading-zero blanking enable.
REQ-007 D  output  8  segments {a,b,c,d,e,f,g,dp}, active-low, registered.
REQ-008 ssd  output  4  digit enables, active-low, bit i = digit i, registered.
REQ-009 frame_tick  output  1  one-cycle pulse marking each shadow load.

Function
REQ-010 The divider SHALL count 0..SCAN_DIV-1 and wrap to 0; in steady state each digit SHALL stay enabled for exactly SCAN_DIV cycles.
REQ-011 The digit index SHALL advance 0->1->2->3->0 on the edge where the divider wraps.
REQ-012 ssd SHALL always have exactly one bit low, equal to the current index: 1110, 1101, 1011, 0111.
REQ-013 A load edge SHALL be the first edge with rst=0 after reset, and every index 3->0 transition.
REQ-014 val, dp_in and blank_lz SHALL be captured into shadow registers only on a load edge; changes between load edges are not displayed until the next load edge.
REQ-015 frame_tick SHALL be 1 for exactly the one cycle following each load edge, 0 otherwise.
REQ-016 D and ssd SHALL update on the same edge; D always shows the shadow digit selected by the new ssd value, including the newly loaded digit 0 on a load edge.
REQ-017 Segment encoding SHALL be standard hex 0-F (b/d lowercase); examples with dp off: 0=00000011, 1=10011111, 2=00100101, 7=00011111, 8=00000001, A=00010001, F=01110001.
REQ-018 D[0] SHALL be 0 when the shadow dp bit for the displayed digit is 1, otherwise 1.
REQ-019 With shadow blank_lz=1, digit i (i=3,2,1) SHALL be blanked (segments a-g = 1) when it and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-020 A blanked digit SHALL still honour its dp bit (D=11111110 when requested).
REQ-021 Behaviour at SCAN_DIV=2 SHALL match REQ-010..REQ-016 with no lost or duplicated digit.

Reset
REQ-022 While rst=1: divider=0, index=0, ssd=1110, D=11111111, frame_tick=0, shadow registers=0.
REQ-023 rst asserted mid-frame SHALL take effect on the next edge regardless of divider or index state.
REQ-024 The first edge with rst=0 SHALL be a load edge, and the divider SHALL count 0->1 on that edge.

Structure
REQ-025 Package ssd_pkg SHALL hold NUM_DIGITS=4, SEG_BLANK=8'hFF and the 16-entry hex segment table.
REQ-026 Sub-module seg_hex_enc SHALL be a purely combinational 4-bit to 7-segment encoder, instantiated once on the selected digit.
REQ-027 ssd_scan SHALL sit downstream of the counter/display path and replace the fixed single-digit enable at top level.

Verification (SCAN_DIV=4)
REQ-028 rst=1 for 3 cycles -> ssd=1110, D=11111111 and frame_tick=0 on every cycle.
REQ-029 val=16'h1208, dp_in=0, blank_lz=0 -> ssd cycles 1110/1101/1011/0111, 4 cycles each; D=00000001, 00000011, 00100101, 10011111; frame_tick period 16 cycles.
REQ-030 Leading-zero blanking: blank_lz=1, val=16'h0007 -> digit0 D=00011111, digits 1-3 D=11111111; val=16'h0000 -> digit0 D=00000011, others blank.
REQ-031 Decimal point: val=16'hFA00, dp_in=4'b0100 -> digit3 D=01110001, digit2 D=00010000.
REQ-032 Mid-frame change: val changed while ssd=1101 -> D unchanged for the rest of that frame; new value appears with ssd=1110 after the next frame_tick.
REQ-033 Reset mid-frame: rst pulsed for 1 cycle while ssd=1011 -> next cycle ssd=1110, D=11111111; the following edge is a load edge with frame_tick=1.
